// File: rtl/reg_file_gen_pkg.sv
// Shared funsel encoding and the per-register next-value function for reg_file_gen.
package reg_file_gen_pkg;

  localparam int unsigned MAX_W = 64;

  localparam logic [2:0] FS_DEC  = 3'b000;
  localparam logic [2:0] FS_INC  = 3'b001;
  localparam logic [2:0] FS_LOAD = 3'b010;
  localparam logic [2:0] FS_CLR  = 3'b011;
  localparam logic [2:0] FS_LDL  = 3'b100;
  localparam logic [2:0] FS_LDH  = 3'b101;
  localparam logic [2:0] FS_SHL  = 3'b110;
  localparam logic [2:0] FS_SAR  = 3'b111;

  typedef struct packed {
    logic [MAX_W-1:0] val;
    logic             wrap;
  } next_t;

  // Operates on a MAX_W container; only the low w bits are meaningful.
  function automatic next_t next_value(logic [2:0] funsel, logic [MAX_W-1:0] old,
                                       logic [MAX_W-1:0] load, int unsigned w);
    next_t            res;
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] hmask;
    logic [MAX_W-1:0] cur;
    int unsigned      half;
    half  = w / 2;
    mask  = (w >= MAX_W) ? '1 : ((64'd1 << w) - 64'd1);
    hmask = (64'd1 << half) - 64'd1;
    cur   = old & mask;
    res   = '0;
    unique case (funsel)
      FS_DEC: begin
        res.val  = (cur - 64'd1) & mask;
        res.wrap = (cur == '0);
      end
      FS_INC: begin
        res.val  = (cur + 64'd1) & mask;
        res.wrap = (cur == mask);
      end
      FS_LOAD: res.val = load & mask;
      FS_CLR:  res.val = '0;
      FS_LDL:  res.val = (cur & ~hmask) | (load & hmask);
      FS_LDH:  res.val = (cur & hmask) | ((load & hmask) << half);
      FS_SHL:  res.val = (cur << 1) & mask;
      FS_SAR:  res.val = (cur >> 1) | ({63'd0, cur[w-1]} << (w - 1));
      default: res.val = cur;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/reg_file_gen_if.sv
// Control/data bundle between the datapath driver and reg_file_gen.
interface reg_file_gen_if #(
  parameter int unsigned W     = 8,
  parameter int unsigned NREG  = 8,
  parameter int unsigned SEL_W = $clog2(NREG)
);
  logic             enable;
  logic [2:0]       funsel;
  logic [NREG-1:0]  rsel;
  logic [W-1:0]     load;
  logic [SEL_W-1:0] o1sel;
  logic [SEL_W-1:0] o2sel;
  logic [NREG-1:0]  clr_flags;
  logic [W-1:0]     o1;
  logic [W-1:0]     o2;
  logic [NREG-1:0]  wrap;
  logic             o1_zero;

  modport master (
    output enable, funsel, rsel, load, o1sel, o2sel, clr_flags,
    input  o1, o2, wrap, o1_zero
  );

  modport slave (
    input  enable, funsel, rsel, load, o1sel, o2sel, clr_flags,
    output o1, o2, wrap, o1_zero
  );
endinterface

// File: rtl/reg_cell_gen.sv
// One W-bit register with its sticky wrap flag; exposes its next value for read forwarding.
module reg_cell_gen
  import reg_file_gen_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [2:0]   funsel,
  input  logic [W-1:0] load,
  input  logic         clr,
  output logic [W-1:0] val_nxt,
  output logic         wrap
);

  logic [W-1:0] val_q, val_d;
  logic         wrap_q, wrap_d;
  next_t        res;
  logic         unused_res;

  always_comb begin
    res     = next_value(funsel, MAX_W'(val_q), MAX_W'(load), W);
    val_d   = we ? res.val[W-1:0] : val_q;
    // Set beats clear when both land on the same edge.
    wrap_d  = (we && res.wrap) || (wrap_q && !clr);
  end

  assign unused_res = ^res;

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      val_q  <= val_d;
      wrap_q <= wrap_d;
    end
  end

  assign val_nxt = rst ? '0 : val_d;
  assign wrap    = wrap_q;

endmodule

// File: rtl/reg_file_gen.sv
// Parametrised register file: masked multi-register writes, sticky wrap flags and two
// registered read ports that forward the same edge's write.
module reg_file_gen
  import reg_file_gen_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned NREG  = 8,
  parameter int unsigned SEL_W = $clog2(NREG)
) (
  input logic          clk,
  input logic          rst,
  reg_file_gen_if.slave bus
);

  logic [W-1:0]    nxt [NREG];
  logic [NREG-1:0] wrap_v;
  logic [W-1:0]    rd1, rd2;
  logic [W-1:0]    o1_q, o2_q;
  logic            zero_q;

  for (genvar i = 0; i < NREG; i++) begin : g_cell
    reg_cell_gen #(
      .W(W)
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .we      (bus.enable && bus.rsel[i]),
      .funsel  (bus.funsel),
      .load    (bus.load),
      .clr     (bus.clr_flags[i]),
      .val_nxt (nxt[i]),
      .wrap    (wrap_v[i])
    );
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int i = 0; i < int'(NREG); i++) begin
      if (bus.o1sel == SEL_W'(i)) rd1 = nxt[i];
      if (bus.o2sel == SEL_W'(i)) rd2 = nxt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o1_q   <= '0;
      o2_q   <= '0;
      zero_q <= 1'b1;
    end else begin
      o1_q   <= rd1;
      o2_q   <= rd2;
      zero_q <= (rd1 == '0);
    end
  end

  assign bus.o1      = o1_q;
  assign bus.o2      = o2_q;
  assign bus.o1_zero = zero_q;
  assign bus.wrap    = wrap_v;

endmodule

// File: tb/tb_reg_file_gen.sv
// Randomised and directed bench for reg_file_gen against an arithmetic reference model.
module tb_reg_file_gen;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  int mreg  [8];
  int mwrap [8];
  int exp_o1, exp_o2;

  reg_file_gen_if #(.W(8), .NREG(8)) bus ();

  reg_file_gen #(.W(8), .NREG(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int model_op(input int f, input int r, input int ld);
    case (f)
      0:       return (r + 255) % 256;
      1:       return (r + 1) % 256;
      2:       return ld;
      3:       return 0;
      4:       return (r / 16) * 16 + ld % 16;
      5:       return (ld % 16) * 16 + r % 16;
      6:       return (r * 2) % 256;
      default: return r / 2 + ((r >= 128) ? 128 : 0);
    endcase
  endfunction

  // Advance one edge: update the model from the current inputs, then check all outputs.
  task automatic step(input string tag);
    int nreg [8];
    int nwrap[8];
    int wexp;
    for (int i = 0; i < 8; i++) begin
      int f, r;
      f = int'(bus.funsel);
      r = mreg[i];
      nreg[i]  = r;
      nwrap[i] = (mwrap[i] != 0 && !bus.clr_flags[i]) ? 1 : 0;
      if (bus.enable && bus.rsel[i]) begin
        nreg[i] = model_op(f, r, int'(bus.load));
        if ((f == 1 && r == 255) || (f == 0 && r == 0)) nwrap[i] = 1;
      end
      if (rst) begin
        nreg[i]  = 0;
        nwrap[i] = 0;
      end
    end
    exp_o1 = nreg[bus.o1sel];
    exp_o2 = nreg[bus.o2sel];
    @(posedge clk);
    #1;
    wexp = 0;
    for (int i = 0; i < 8; i++) begin
      mreg[i]  = nreg[i];
      mwrap[i] = nwrap[i];
      wexp     = wexp | (nwrap[i] << i);
    end
    check_eq({tag, ".o1"}, 32'(bus.o1), 32'(exp_o1));
    check_eq({tag, ".o2"}, 32'(bus.o2), 32'(exp_o2));
    check_eq({tag, ".wrap"}, 32'(bus.wrap), 32'(wexp));
    check_eq({tag, ".zero"}, 32'(bus.o1_zero), (exp_o1 == 0) ? 32'd1 : 32'd0);
  endtask

  task automatic idle_inputs();
    rst           = 1'b0;
    bus.enable    = 1'b0;
    bus.funsel    = 3'd0;
    bus.rsel      = 8'h00;
    bus.load      = 8'h00;
    bus.clr_flags = 8'h00;
  endtask

  task automatic sweep(input string tag);
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      bus.o1sel = 3'(i);
      bus.o2sel = 3'(7 - i);
      step(tag);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      mreg[i]  = 0;
      mwrap[i] = 0;
    end
    idle_inputs();
    rst       = 1'b1;
    bus.o1sel = 3'd0;
    bus.o2sel = 3'd0;
    step("reset");
    check_eq("reset_o1_zero", 32'(bus.o1_zero), 32'd1);

    // 1: multi-register load
    rst = 1'b0; bus.enable = 1'b1; bus.funsel = 3'b010; bus.load = 8'h95;
    bus.rsel = 8'h14; bus.o1sel = 3'd2; bus.o2sel = 3'd4;
    step("t1");
    check_eq("t1_o1", 32'(bus.o1), 32'h95);
    check_eq("t1_o2", 32'(bus.o2), 32'h95);
    sweep("t1_sweep");

    // 2: increment wrap, sticky, set-beats-clear, then clear
    bus.enable = 1'b1; bus.rsel = 8'h01; bus.funsel = 3'b010; bus.load = 8'hFF;
    bus.o1sel = 3'd0; bus.o2sel = 3'd0;
    step("t2_ld");
    bus.funsel = 3'b001;
    step("t2_inc1");
    check_eq("t2_inc1_o1", 32'(bus.o1), 32'h00);
    check_eq("t2_inc1_wrap0", 32'(bus.wrap[0]), 32'd1);
    step("t2_inc2");
    check_eq("t2_inc2_o1", 32'(bus.o1), 32'h01);
    bus.funsel = 3'b011;
    step("t2_clr");
    bus.funsel = 3'b000; bus.clr_flags = 8'h01;
    step("t2_dec");
    check_eq("t2_dec_o1", 32'(bus.o1), 32'hFF);
    check_eq("t2_dec_wrap0", 32'(bus.wrap[0]), 32'd1);
    bus.enable = 1'b0;
    step("t2_flagclr");
    check_eq("t2_flagclr_wrap0", 32'(bus.wrap[0]), 32'd0);
    bus.clr_flags = 8'h00;

    // 3: half loads
    bus.enable = 1'b1; bus.rsel = 8'h08; bus.funsel = 3'b011; bus.o1sel = 3'd3;
    step("t3_clr");
    bus.funsel = 3'b100; bus.load = 8'h0A;
    step("t3_ldl");
    check_eq("t3_ldl_o1", 32'(bus.o1), 32'h0A);
    bus.funsel = 3'b101; bus.load = 8'h05;
    step("t3_ldh");
    check_eq("t3_ldh_o1", 32'(bus.o1), 32'h5A);

    // 4: shifts
    bus.rsel = 8'h20; bus.funsel = 3'b010; bus.load = 8'h95; bus.o1sel = 3'd5;
    step("t4_ld");
    bus.funsel = 3'b111;
    step("t4_sar");
    check_eq("t4_sar_o1", 32'(bus.o1), 32'hCA);
    bus.funsel = 3'b110;
    step("t4_shl");
    check_eq("t4_shl_o1", 32'(bus.o1), 32'h94);

    // 5: enable low blocks writes; o2 follows its select one edge later
    bus.enable = 1'b0; bus.funsel = 3'b011; bus.rsel = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      bus.o2sel = 3'(i + 3);
      step("t5");
    end
    sweep("t5_sweep");

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      rst           = ($urandom_range(0, 31) == 0);
      bus.enable    = ($urandom_range(0, 3) != 0);
      bus.funsel    = 3'($urandom);
      bus.rsel      = 8'($urandom);
      bus.load      = 8'($urandom);
      bus.o1sel     = 3'($urandom);
      bus.o2sel     = 3'($urandom);
      bus.clr_flags = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      step("rand");
    end

    // 6: reset during a full-width write
    bus.enable = 1'b1; bus.rsel = 8'hFF; bus.funsel = 3'b001; bus.clr_flags = 8'h00;
    step("t6_pre");
    rst = 1'b1; bus.funsel = 3'b010; bus.load = 8'h3C; bus.o1sel = 3'd1; bus.o2sel = 3'd6;
    step("t6_rst");
    check_eq("t6_o1", 32'(bus.o1), 32'h00);
    check_eq("t6_wrap", 32'(bus.wrap), 32'h00);
    check_eq("t6_zero", 32'(bus.o1_zero), 32'd1);
    sweep("t6_sweep");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_gen.md
Name: reg_file_gen

Overview:
- Parametrised successor to the fixed 8x8 register file.
- NREG registers of W bits each, with multi-register masked writes and an extended 3-bit function select that adds half-word loads and shifts.
- Per-register sticky wrap flags.
- Two registered read ports that forward same-cycle updates.
- Sits between the data mux and the ALU A/B inputs in the datapath.

Parameters:
- W, 8, register width in bits; must be even and at least 4.
- NREG, 8, number of registers; must be at least 2.
- SEL_W, $clog2(NREG), width of the read-select fields.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  global write enable; when 0, no register or flag update happens from funsel.
- funsel  input  3  operation applied to every selected register.
- rsel  input  NREG  write mask; bit i selects register i; any number of bits may be set.
- load  input  W  data input.
- o1sel  input  SEL_W  read-port-1 register index.
- o2sel  input  SEL_W  read-port-2 register index.
- clr_flags  input  NREG  per-register wrap-flag clear mask.
- o1  output  W  registered read port 1.
- o2  output  W  registered read port 2.
- wrap  output  NREG  sticky wrap flags.
- o1_zero  output  1  registered; 1 when o1 == 0.

Behaviour:
- Reset: when rst=1 at an edge, all registers, o1, o2 and wrap go to 0, and o1_zero goes to 1. Reset overrides enable, funsel and clr_flags.
- Write: at an edge with enable=1, each register i with rsel[i]=1 gets next = f(funsel, reg[i], load). Unselected registers hold their value.
- funsel encoding:
  - 000 decrement, modulo 2^W.
  - 001 increment, modulo 2^W.
  - 010 load full: next = load.
  - 011 clear: next = 0.
  - 100 load low half: low W/2 bits = load[W/2-1:0]; high half holds.
  - 101 load high half: high W/2 bits = load[W/2-1:0]; low half holds.
  - 110 shift left logical by 1; LSB becomes 0.
  - 111 shift right arithmetic by 1; MSB is replicated.
- Wrap flags:
  - wrap[i] sets when register i is written by increment from all-ones, or by decrement from 0.
  - The flag stays set until a cycle with clr_flags[i]=1.
  - If set and clear happen in the same cycle, set wins.
  - clr_flags acts regardless of enable.
- Read ports:
  - At every edge, o1 <= next-state of register o1sel and o2 <= next-state of register o2sel.
  - Reads therefore reflect that edge's write: one-cycle latency from the select change, zero extra cycles for forwarding a write.
  - o1sel and o2sel may be equal; both ports then show the same value.
  - An out-of-range index (possible only when NREG is not a power of 2) reads 0.
- o1_zero is computed from the same next value that is loaded into o1.
- rsel=0 or enable=0: no state change except flag clears and read-port updates.
- Reset asserted during a multi-register write: reset wins, and no partial update is visible.

Decomposition:
- Shared package holds:
  - the funsel encoding constants FS_DEC, FS_INC, FS_LOAD, FS_CLR, FS_LDL, FS_LDH, FS_SHL, FS_SAR;
  - a function returning the next value and the wrap bit for a given funsel, old value and load.
- One sub-module, reg_cell_gen: a single W-bit register with its wrap flag, instantiated NREG times through a generate loop.
- Read muxes and the zero detect live in the top level.

Test Plan (W=8, NREG=8):
1. Reset, then load to several registers at once.
   - Stimulus: rst=1 for 1 cycle; then enable=1, funsel=010, load=0x95, rsel=0x14, o1sel=2, o2sel=4.
   - Required: after that edge o1=0x95, o2=0x95, o1_zero=0; all other registers are 0.
2. Increment wrap.
   - Stimulus: load R0=0xFF, then funsel=001, rsel=0x01, o1sel=0.
   - Required: o1=0x00, wrap[0]=1, o1_zero=1.
   - A second increment gives o1=0x01 with wrap[0] still 1.
   - clr_flags=0x01 together with a decrement of R0=0x00 gives o1=0xFF, wrap[0]=1 (set wins).
3. Half loads.
   - Stimulus: R3=0x00; funsel=100, load=0x0A; then funsel=101, load=0x05.
   - Required: o1(sel 3) shows 0x0A, then 0x5A.
4. Shifts.
   - Stimulus: R5=0x95; funsel=111; then funsel=110.
   - Required: 0xCA, then 0x94.
5. Enable low.
   - Stimulus: enable=0, funsel=011, rsel=0xFF for 3 cycles.
   - Required: all registers unchanged; changing o2sel updates o2 one edge later.
6. Reset during a write.
   - Stimulus: rst=1 in the same cycle as funsel=010, rsel=0xFF, load=0x3C.
   - Required: all registers=0, o1=o2=0, wrap=0, o1_zero=1.
